// File: rtl/bf16_pkg.sv
// Shared bfloat16 definitions: field widths, canonical NaN, compare codes,
// NaN detection and the arg-extreme sequencer state encoding.
package bf16_pkg;

  localparam int SIGN_W = 1;
  localparam int EXP_W  = 8;
  localparam int MAN_W  = 7;

  localparam logic [15:0] BF16_CANON_NAN = 16'h7FC0;

  localparam logic [1:0] CMP_EQ    = 2'b00;
  localparam logic [1:0] CMP_LT    = 2'b01;
  localparam logic [1:0] CMP_GT    = 2'b10;
  localparam logic [1:0] CMP_UNORD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } seq_state_e;

  function automatic logic is_nan(input logic [15:0] x);
    return (x[MAN_W +: EXP_W] == {EXP_W{1'b1}}) && (x[MAN_W-1:0] != '0);
  endfunction

endpackage

// File: rtl/bf16_cmp.sv
// Combinational sign-correct bf16 compare of a_i against b_i.
// Result is UNORD when either operand is NaN; +0 and -0 compare equal.
module bf16_cmp
  import bf16_pkg::*;
(
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [1:0]  res_o
);

  logic [15:0] norm_a, norm_b;
  logic [15:0] key_a, key_b;

  always_comb begin
    // Fold -0 onto +0, then map to an unsigned key that orders like the reals.
    norm_a = (a_i[14:0] == 15'd0) ? 16'h0000 : a_i;
    norm_b = (b_i[14:0] == 15'd0) ? 16'h0000 : b_i;
    key_a  = norm_a[15] ? ~norm_a : (norm_a | 16'h8000);
    key_b  = norm_b[15] ? ~norm_b : (norm_b | 16'h8000);

    if (is_nan(a_i) || is_nan(b_i)) begin
      res_o = CMP_UNORD;
    end else if (key_a > key_b) begin
      res_o = CMP_GT;
    end else if (key_a < key_b) begin
      res_o = CMP_LT;
    end else begin
      res_o = CMP_EQ;
    end
  end

endmodule

// File: rtl/bf16_argext_seq.sv
// Streaming arg-max / arg-min over a bf16 vector, one element per cycle,
// with NaN tracking and forced termination at MAX_LEN elements.
module bf16_argext_seq
  import bf16_pkg::*;
#(
  parameter int MAX_LEN = 256,
  parameter int IDX_W   = $clog2(MAX_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode_min,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_val,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_nan,
  output logic             out_all_nan,
  output logic             out_trunc
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_LEN - 1);

  seq_state_e       state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             mode_q, mode_d;
  logic [15:0]      acc_val_q, acc_val_d;
  logic [IDX_W-1:0] acc_idx_q, acc_idx_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             nan_q, nan_d;
  logic             all_nan_q, all_nan_d;
  logic             trunc_q, trunc_d;

  logic       xfer;
  logic       elem_nan;
  logic       better;
  logic [1:0] cmp_res;

  bf16_cmp u_cmp (
    .a_i   (in_data),
    .b_i   (acc_val_q),
    .res_o (cmp_res)
  );

  assign xfer     = in_valid && in_ready_q;
  assign elem_nan = is_nan(in_data);
  assign better   = mode_q ? (cmp_res == CMP_LT) : (cmp_res == CMP_GT);

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    acc_val_d = acc_val_q;
    acc_idx_d = acc_idx_q;
    cnt_d     = cnt_q;
    nan_d     = nan_q;
    all_nan_d = all_nan_q;
    trunc_d   = trunc_q;

    unique case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          mode_d    = mode_min;
          acc_val_d = elem_nan ? BF16_CANON_NAN : in_data;
          acc_idx_d = '0;
          cnt_d     = IDX_W'(1);
          nan_d     = elem_nan;
          all_nan_d = elem_nan;
          trunc_d   = 1'b0;
          state_d   = in_last ? ST_DONE : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (xfer) begin
          cnt_d = cnt_q + 1'b1;
          if (elem_nan) begin
            nan_d = 1'b1;
          end else if (all_nan_q || better) begin
            // While only NaNs have been seen the accumulator holds no real value.
            acc_val_d = in_data;
            acc_idx_d = cnt_q;
            all_nan_d = 1'b0;
          end
          if (in_last) begin
            state_d = ST_DONE;
          end else if (cnt_q == LAST_IDX) begin
            state_d = ST_DONE;
            trunc_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d = (state_d != ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      in_ready_q <= 1'b0;
      mode_q     <= 1'b0;
      acc_val_q  <= '0;
      acc_idx_q  <= '0;
      cnt_q      <= '0;
      nan_q      <= 1'b0;
      all_nan_q  <= 1'b0;
      trunc_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      mode_q     <= mode_d;
      acc_val_q  <= acc_val_d;
      acc_idx_q  <= acc_idx_d;
      cnt_q      <= cnt_d;
      nan_q      <= nan_d;
      all_nan_q  <= all_nan_d;
      trunc_q    <= trunc_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = (state_q == ST_DONE);
  assign out_val     = acc_val_q;
  assign out_idx     = acc_idx_q;
  assign out_nan     = nan_q;
  assign out_all_nan = all_nan_q;
  assign out_trunc   = trunc_q;

endmodule

// File: tb/tb_bf16_argext_seq.sv
// Scoreboard bench for bf16_argext_seq built with MAX_LEN=4 so that the
// truncation boundary is reachable with short vectors.
module tb_bf16_argext_seq;

  localparam int MAX_LEN = 4;
  localparam int IDX_W   = 2;

  logic             clk;
  logic             rst_n;
  logic             mode_min;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_val;
  logic [IDX_W-1:0] out_idx;
  logic             out_nan;
  logic             out_all_nan;
  logic             out_trunc;

  typedef struct packed {
    logic [15:0]      val;
    logic [IDX_W-1:0] idx;
    logic             nan;
    logic             all_nan;
    logic             trunc;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  exp_t        got;
  logic [15:0] vec [0:7];
  int          errors = 0;
  int          checks = 0;
  logic        last_valid;
  logic        early_valid;
  logic        ok;

  bf16_argext_seq #(.MAX_LEN(MAX_LEN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mode_min    (mode_min),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_val     (out_val),
    .out_idx     (out_idx),
    .out_nan     (out_nan),
    .out_all_nan (out_all_nan),
    .out_trunc   (out_trunc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Real-number ordering of a bf16 pattern as a signed integer key.
  function automatic int key(input logic [15:0] x);
    int m;
    m = int'(x[14:0]);
    return x[15] ? -m : m;
  endfunction

  function automatic exp_t model(input bit mn, input int n, input bit tr);
    exp_t r;
    bit   have;
    int   best;
    have      = 1'b0;
    best      = 0;
    r.val     = 16'h7FC0;
    r.idx     = '0;
    r.nan     = 1'b0;
    r.trunc   = tr;
    for (int i = 0; i < n; i++) begin
      if (vec[i][14:7] == 8'hFF && vec[i][6:0] != 7'd0) begin
        r.nan = 1'b1;
      end else if (!have || (mn ? key(vec[i]) < best : key(vec[i]) > best)) begin
        have  = 1'b1;
        best  = key(vec[i]);
        r.val = vec[i];
        r.idx = IDX_W'(i);
      end
    end
    r.all_nan = !have;
    return r;
  endfunction

  task automatic send(input logic [15:0] d, input logic last, input logic mn);
    int w;
    w = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    mode_min = mn;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready=%b after %0d cycles, want 1", in_ready, w);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input bit mn, input int n, input bit tr);
    sb.push_back(model(mn, n, tr));
    early_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      send(vec[i], (i == n - 1) && !tr, mn);
      if (i == n - 2) early_valid = out_valid;
      if (i == n - 1) last_valid = out_valid;
    end
  endtask

  task automatic collect(output logic got_ok);
    int w;
    w = 0;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (!out_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    got_ok = out_valid;
    got    = {out_val, out_idx, out_nan, out_all_nan, out_trunc};
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    mode_min  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, out_val, out_idx, out_nan, out_all_nan, out_trunc} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: in_ready=%b out_valid=%b val=%h idx=%0d nan=%b all_nan=%b trunc=%b, want all 0",
               in_ready, out_valid, out_val, out_idx, out_nan, out_all_nan, out_trunc);
    end else $display("reset: outputs 0, in_ready 0");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b, want 1", in_ready);
    end else $display("reset release: in_ready 1");
  endtask

  task automatic test_basic_max();
    vec[0] = 16'h3F80; vec[1] = 16'hC000; vec[2] = 16'h4000; vec[3] = 16'h3F00;
    run_vec(1'b0, 4, 1'b0);
    checks++;
    if (early_valid !== 1'b0 || last_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_latency: valid before last=%b at last=%b, want 0 1", early_valid, last_valid);
    end
    collect(ok);
    e = sb.pop_front();
    checks++;
    if (!ok || got !== e) begin
      errors++;
      $display("FAIL basic_max: val=%h idx=%0d nan=%b all_nan=%b trunc=%b, want val=%h idx=%0d nan=%b all_nan=%b trunc=%b",
               got.val, got.idx, got.nan, got.all_nan, got.trunc, e.val, e.idx, e.nan, e.all_nan, e.trunc);
    end else $display("basic_max: val=%h idx=%0d", got.val, got.idx);
  endtask

  task automatic test_negative();
    int n;
    bit mn;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        vec[0] = 16'hBF80; vec[1] = 16'hC000; vec[2] = 16'h3F80; n = 3; mn = 1'b1;
      end else begin
        vec[0] = 16'hC000; vec[1] = 16'hBF80; n = 2; mn = 1'b0;
      end
      run_vec(mn, n, 1'b0);
      collect(ok);
      e = sb.pop_front();
      checks++;
      if (!ok || got !== e) begin
        errors++;
        $display("FAIL negative[%0d]: val=%h idx=%0d nan=%b all_nan=%b trunc=%b, want val=%h idx=%0d nan=%b all_nan=%b trunc=%b",
                 k, got.val, got.idx, got.nan, got.all_nan, got.trunc, e.val, e.idx, e.nan, e.all_nan, e.trunc);
      end else $display("negative[%0d]: val=%h idx=%0d", k, got.val, got.idx);
    end
  endtask

  task automatic test_ties();
    int n;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        vec[0] = 16'h8000; vec[1] = 16'h0000; vec[2] = 16'h8000; n = 3;
      end else begin
        vec[0] = 16'h4000; vec[1] = 16'h4000; n = 2;
      end
      run_vec(1'b0, n, 1'b0);
      collect(ok);
      e = sb.pop_front();
      checks++;
      if (!ok || got !== e) begin
        errors++;
        $display("FAIL ties[%0d]: val=%h idx=%0d nan=%b all_nan=%b trunc=%b, want val=%h idx=%0d nan=%b all_nan=%b trunc=%b",
                 k, got.val, got.idx, got.nan, got.all_nan, got.trunc, e.val, e.idx, e.nan, e.all_nan, e.trunc);
      end else $display("ties[%0d]: val=%h idx=%0d", k, got.val, got.idx);
    end
  endtask

  task automatic test_nan();
    int n;
    bit mn;
    for (int k = 0; k < 3; k++) begin
      if (k == 0) begin
        vec[0] = 16'h3F80; vec[1] = 16'h7FC1; vec[2] = 16'h4000; n = 3; mn = 1'b0;
      end else if (k == 1) begin
        vec[0] = 16'hFF81; vec[1] = 16'h7FC1; n = 2; mn = 1'b0;
      end else begin
        vec[0] = 16'h7FC1; vec[1] = 16'h4000; vec[2] = 16'h3F80; n = 3; mn = 1'b1;
      end
      run_vec(mn, n, 1'b0);
      collect(ok);
      e = sb.pop_front();
      checks++;
      if (!ok || got !== e) begin
        errors++;
        $display("FAIL nan[%0d]: val=%h idx=%0d nan=%b all_nan=%b trunc=%b, want val=%h idx=%0d nan=%b all_nan=%b trunc=%b",
                 k, got.val, got.idx, got.nan, got.all_nan, got.trunc, e.val, e.idx, e.nan, e.all_nan, e.trunc);
      end else $display("nan[%0d]: val=%h idx=%0d nan=%b all_nan=%b", k, got.val, got.idx, got.nan, got.all_nan);
    end
  endtask

  task automatic test_backpressure();
    exp_t snap;
    exp_t cur;
    @(negedge clk);
    out_ready = 1'b0;
    vec[0] = 16'h3F00; vec[1] = 16'h3F80; vec[2] = 16'hC000;
    run_vec(1'b0, 3, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    snap = {out_val, out_idx, out_nan, out_all_nan, out_trunc};
    e = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || snap !== e) begin
      errors++;
      $display("FAIL bp_first: valid=%b val=%h idx=%0d, want valid=1 val=%h idx=%0d", out_valid, snap.val, snap.idx, e.val, e.idx);
    end else $display("bp_first: val=%h idx=%0d", snap.val, snap.idx);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cur = {out_val, out_idx, out_nan, out_all_nan, out_trunc};
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || cur !== snap) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid=%b in_ready=%b val=%h idx=%0d, want valid=1 in_ready=0 val=%h idx=%0d",
                 i, out_valid, in_ready, cur.val, cur.idx, snap.val, snap.idx);
      end else $display("bp_hold[%0d]: stable", i);
      in_valid = i[0];
      in_data  = 16'h4100;
      in_last  = 1'b0;
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    vec[0] = 16'h4100; vec[1] = 16'hC100; vec[2] = 16'h4200;
    run_vec(1'b0, 3, 1'b0);
    collect(ok);
    e = sb.pop_front();
    checks++;
    if (!ok || got !== e) begin
      errors++;
      $display("FAIL bp_second: val=%h idx=%0d nan=%b all_nan=%b trunc=%b, want val=%h idx=%0d nan=%b all_nan=%b trunc=%b",
               got.val, got.idx, got.nan, got.all_nan, got.trunc, e.val, e.idx, e.nan, e.all_nan, e.trunc);
    end else $display("bp_second: val=%h idx=%0d", got.val, got.idx);
  endtask

  task automatic test_back_to_back();
    vec[0] = 16'h3F80;
    out_ready = 1'b1;
    run_vec(1'b1, 1, 1'b0);
    got = {out_val, out_idx, out_nan, out_all_nan, out_trunc};
    e = sb.pop_front();
    checks++;
    if (last_valid !== 1'b1 || got !== e) begin
      errors++;
      $display("FAIL b2b_single: valid=%b val=%h idx=%0d, want valid=1 val=%h idx=%0d", last_valid, got.val, got.idx, e.val, e.idx);
    end else $display("b2b_single: val=%h idx=%0d", got.val, got.idx);
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_handshake: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end else $display("b2b_handshake: released");
    vec[0] = 16'hC000; vec[1] = 16'hC080;
    run_vec(1'b1, 2, 1'b0);
    collect(ok);
    e = sb.pop_front();
    checks++;
    if (!ok || got !== e) begin
      errors++;
      $display("FAIL b2b_second: val=%h idx=%0d nan=%b all_nan=%b trunc=%b, want val=%h idx=%0d nan=%b all_nan=%b trunc=%b",
               got.val, got.idx, got.nan, got.all_nan, got.trunc, e.val, e.idx, e.nan, e.all_nan, e.trunc);
    end else $display("b2b_second: val=%h idx=%0d", got.val, got.idx);
  endtask

  task automatic test_trunc_reset();
    logic saw_valid;
    vec[0] = 16'h3F80; vec[1] = 16'h4000; vec[2] = 16'h3F00; vec[3] = 16'hC000;
    run_vec(1'b0, 4, 1'b1);
    collect(ok);
    e = sb.pop_front();
    checks++;
    if (last_valid !== 1'b1 || !ok || got !== e) begin
      errors++;
      $display("FAIL trunc: valid_at_4th=%b val=%h idx=%0d trunc=%b, want valid=1 val=%h idx=%0d trunc=%b",
               last_valid, got.val, got.idx, got.trunc, e.val, e.idx, e.trunc);
    end else $display("trunc: val=%h idx=%0d trunc=%b", got.val, got.idx, got.trunc);
    vec[0] = 16'h4040; vec[1] = 16'h3F80;
    run_vec(1'b0, 2, 1'b0);
    collect(ok);
    e = sb.pop_front();
    checks++;
    if (!ok || got !== e) begin
      errors++;
      $display("FAIL after_trunc: val=%h idx=%0d trunc=%b, want val=%h idx=%0d trunc=%b", got.val, got.idx, got.trunc, e.val, e.idx, e.trunc);
    end else $display("after_trunc: val=%h idx=%0d trunc=%b", got.val, got.idx, got.trunc);
    send(16'h4300, 1'b0, 1'b0);
    send(16'h4400, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, out_val, out_idx, out_nan, out_all_nan, out_trunc} !== '0) begin
      errors++;
      $display("FAIL mid_reset: in_ready=%b out_valid=%b val=%h idx=%0d, want all 0", in_ready, out_valid, out_val, out_idx);
    end else $display("mid_reset: outputs 0");
    @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    checks++;
    if (saw_valid !== 1'b0) begin
      errors++;
      $display("FAIL stale_result: out_valid seen=%b after reset, want 0", saw_valid);
    end else $display("post_reset: no stale result");
    vec[0] = 16'hBF00; vec[1] = 16'h3F00;
    run_vec(1'b0, 2, 1'b0);
    collect(ok);
    e = sb.pop_front();
    checks++;
    if (!ok || got !== e) begin
      errors++;
      $display("FAIL post_reset_vec: val=%h idx=%0d trunc=%b, want val=%h idx=%0d trunc=%b", got.val, got.idx, got.trunc, e.val, e.idx, e.trunc);
    end else $display("post_reset_vec: val=%h idx=%0d", got.val, got.idx);
  endtask

  initial begin
    test_reset();
    test_basic_max();
    test_negative();
    test_ties();
    test_nan();
    test_backpressure();
    test_back_to_back();
    test_trunc_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bf16_argext_seq.md
# bf16_argext_seq

Streaming arg-max/arg-min sequencer for bfloat16 vectors. It accepts one element per cycle over a valid/ready stream and tracks the running extreme value and its index using a single bf16 magnitude/sign comparator. When the vector ends, it presents the result on a held output handshake. It sits between the operand buffer and the result writeback path of the accelerator, and is used for max-pooling and softmax-max reductions.

## Interface
- `MAX_LEN`, 256: maximum elements per vector. Must be a power of two and at least 2.
- `IDX_W`, `$clog2(MAX_LEN)`: width of the index output.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `mode_min` in 1: 0 selects arg-max, 1 selects arg-min. Sampled with element 0 of each vector.
- `in_valid` in 1: input element valid.
- `in_ready` out 1: block can accept an element.
- `in_data` in 16: bf16 element.
- `in_last` in 1: marks the final element of the vector.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts the result.
- `out_val` out 16: extreme value.
- `out_idx` out `IDX_W`: index of the extreme value, counted from 0.
- `out_nan` out 1: at least one NaN was seen in the vector.
- `out_all_nan` out 1: every element of the vector was NaN.
- `out_trunc` out 1: the vector was force-terminated at `MAX_LEN` elements.

## Operation
- **States.**
  - IDLE: `in_ready`=1, waiting for element 0.
  - ACCUM: `in_ready`=1.
  - DONE: `in_ready`=0, `out_valid`=1.
- **Transfers.** An element transfers when `in_valid && in_ready`.
- **IDLE transitions.**
  - Element 0 transfers with `in_last`=0: go to ACCUM.
  - Element 0 transfers with `in_last`=1: go to DONE.
- **ACCUM transitions.**
  - An element transfers with `in_last`=1: go to DONE.
  - The transferred element has index `MAX_LEN-1` and `in_last`=0: go to DONE and set `out_trunc`=1. The next element starts a new vector.
- **DONE transitions.** `out_valid && out_ready` returns the block to IDLE.
- **Element 0.**
  - Loads the accumulator and index counter unconditionally.
  - Latches `mode_min` for the whole vector.
  - Clears the sticky flags.
- **Comparison ordering** (applies to elements 1..n-1):
  - Sign first: any negative is less than any non-negative.
  - Same sign, both positive: compare exponent, then mantissa.
  - Same sign, both negative: the ordering is reversed.
  - +0 and -0 compare equal.
  - Infinities and subnormals are ordinary values in this ordering.
- **Update rule.** Replace the accumulator and index only on a strict GT (max mode) or strict LT (min mode). On ties, the earliest index is retained.
- **NaN** (exp=FF, mant≠0):
  - A NaN is never selected. It sets `out_nan`.
  - If the accumulator holds no valid value yet, the first non-NaN element loads it.
  - All-NaN vector: `out_val`=16'h7FC0, `out_idx`=0, `out_all_nan`=1.
- **Width.** The index counter is `IDX_W` bits and never wraps inside a vector, because truncation fires at `MAX_LEN-1`.

## Timing
- **Reset.** All outputs reset to 0, state resets to IDLE, and `in_ready` is 0 during reset.
  - Reset deassertion: `in_ready`=1 on the first clock after release.
  - Reset mid-vector: the partial result is discarded. No `out_valid` is produced for it.
- **Latency.** `out_valid` rises on the clock edge that accepts the last element.
- **Throughput.**
  - 1 element per cycle inside a vector.
  - Minimum 1 bubble cycle between vectors: the DONE→IDLE cycle, during which `in_ready`=0.
- **Backpressure.** While `out_valid`=1 and `out_ready`=0, all `out_*` signals hold stable and `in_ready` stays 0.
- **Simultaneous events.** `out_ready` asserted in the same cycle `out_valid` rises completes the handshake that cycle. The next element is accepted one cycle later.
- **Path.** The comparator path is combinational from the accumulator and `in_data` into the registers, with a single-cycle path.

## Structure
- **Shared package `bf16_pkg`:**
  - Field widths (sign 1, exponent 8, mantissa 7).
  - Canonical NaN 16'h7FC0.
  - Compare codes: EQ=2'b00, LT=2'b01, GT=2'b10, UNORD=2'b11.
  - `is_nan` function.
  - Sequencer state enum.
- **Sub-module `bf16_cmp`:** combinational, sign-correct compare. Returns UNORD if either operand is NaN. Instantiated once.

## Test plan
- **Basic max.** Max over 3F80, C000, 4000, 3F00 (last on the 4th) → `out_val`=4000, `out_idx`=2, `out_valid` on the accept edge of element 3.
- **Negative ordering.** Min over BF80, C000, 3F80 → C000, `idx`=1. Max over C000, BF80 → BF80, `idx`=1.
- **Ties and signed zero.** Max over 8000, 0000, 8000 → 8000, `idx`=0. Max over 4000, 4000 → `idx`=0.
- **NaN.** 3F80, 7FC1, 4000 → 4000, `idx`=2, `out_nan`=1. Vector FF81, 7FC1 → 7FC0, `idx`=0, `out_all_nan`=1.
- **Backpressure.** Hold `out_ready`=0 for 5 cycles with gappy `in_valid` → outputs stable and `in_ready`=0 throughout. The second vector is correct after the handshake.
- **Truncation and reset.** With `MAX_LEN`=4, send 5 elements without `in_last`:
  - The first result has `out_trunc`=1 and `idx` ≤ 3.
  - The 5th element forms a new vector.
  - Assert `rst_n`=0 mid-vector → all outputs 0 and no stale result after release.
